// File: rtl/escalonador_somatorio_pkg.sv
// Shared types and defaults for the round-robin summation scheduler.
package escalonador_somatorio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_N_TERMS = 3;

endpackage

// File: rtl/escalonador_somatorio_acumulador.sv
// Signed accumulator with sticky two's-complement overflow.
module acumulador_somatorio
    import escalonador_somatorio_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] operando,
    output logic [WIDTH-1:0] soma_nx,
    output logic             ovf_nx
);

    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic             add_ovf;

    // soma_nx/ovf_nx include the current operand so the final add can be
    // published on the same edge that commits it.
    always_comb begin
        soma_nx = acc + operando;
        add_ovf = (acc[WIDTH-1] == operando[WIDTH-1]) &&
                  (soma_nx[WIDTH-1] != acc[WIDTH-1]);
        ovf_nx  = ovf | add_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= soma_nx;
            ovf <= ovf_nx;
        end
    end

endmodule

// File: rtl/escalonador_somatorio.sv
// Round-robin scheduler sharing one signed summation datapath.
module escalonador_somatorio
    import escalonador_somatorio_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] valor,
    output logic [N_REQ-1:0]       gnt,
    output logic                   take,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [WIDTH-1:0]       soma,
    output logic                   overflow
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_TERMS - 1);

    estado_t          estado;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  vencedor;
    logic [ID_W-1:0]  cand;
    logic             achou;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] lane;
    logic [WIDTH-1:0] soma_nx;
    logic             ovf_nx;

    // First requester after ptr, searching circularly.
    always_comb begin
        vencedor = ptr;
        cand     = ptr;
        achou    = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!achou && req[cand]) begin
                achou    = 1'b1;
                vencedor = cand;
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == id) begin
                lane = valor[k*WIDTH +: WIDTH];
            end
        end
    end

    acumulador_somatorio #(
        .WIDTH(WIDTH)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clr     (estado == IDLE),
        .en      (estado == ACC),
        .operando(lane),
        .soma_nx (soma_nx),
        .ovf_nx  (ovf_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= IDLE;
            id       <= '0;
            ptr      <= ID_W'(N_REQ - 1);
            cnt      <= '0;
            gnt      <= '0;
            take     <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            soma     <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (achou) begin
                        id     <= vencedor;
                        cnt    <= '0;
                        gnt    <= N_REQ'(1) << vencedor;
                        take   <= 1'b1;
                        estado <= ACC;
                    end
                end
                ACC: begin
                    if (!req[id]) begin
                        gnt    <= '0;
                        take   <= 1'b0;
                        ptr    <= id;
                        estado <= IDLE;
                    end else if (cnt == ULTIMO) begin
                        gnt      <= '0;
                        take     <= 1'b0;
                        done     <= 1'b1;
                        soma     <= soma_nx;
                        overflow <= ovf_nx;
                        done_id  <= id;
                        estado   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ptr    <= id;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_somatorio.sv
// Directed self-checking bench for escalonador_somatorio.
module tb_escalonador_somatorio;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] valor;
    logic [3:0]  gnt;
    logic        take;
    logic        done;
    logic [1:0]  done_id;
    logic [5:0]  soma;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0, t1;

    logic [5:0] ops [4][3];
    int         idx [4];

    escalonador_somatorio #(
        .N_REQ(4), .WIDTH(6), .N_TERMS(3), .ID_W(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .valor   (valor),
        .gnt     (gnt),
        .take    (take),
        .done    (done),
        .done_id (done_id),
        .soma    (soma),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: advance operand after each consumed take.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 4; k++) begin
            if (reset)
                idx[k] <= 0;
            else if (!req[k] || (done && int'(done_id) == k))
                idx[k] <= 0;
            else if (gnt[k] && take)
                idx[k] <= idx[k] + 1;
        end
    end

    always_comb begin
        valor = '0;
        for (int k = 0; k < 4; k++)
            valor[k*6 +: 6] = ops[k][(idx[k] > 2) ? 2 : idx[k]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [5:0] a,
                           input logic [5:0] b, input logic [5:0] c);
        ops[k][0] = a;
        ops[k][1] = b;
        ops[k][2] = c;
    endtask

    task automatic servir(input string tag, input int k,
                          input logic [5:0] es, input logic eo,
                          output int t_done);
        int n = 0;
        while (gnt == 4'b0000 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << k);
        chk({tag, "_take"}, 32'(take), 32'd1);
        repeat (2) begin
            tick();
            chk({tag, "_gnt_hold"}, 32'(gnt), 32'(1) << k);
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_gnt_off"}, 32'(gnt), 32'd0);
        chk({tag, "_soma"}, {26'd0, soma}, {26'd0, es});
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_id"}, 32'(done_id), 32'(k));
        t_done = cyc;
        tick();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_soma_hold"}, {26'd0, soma}, {26'd0, es});
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) set_ops(k, 6'd0, 6'd0, 6'd0);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_take", 32'(take), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_id", 32'(done_id), 32'd0);
        chk("rst_soma", {26'd0, soma}, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: plain sum
        set_ops(0, 6'd5, 6'd7, -6'sd3);
        req = 4'b0001;
        servir("t1", 0, 6'd9, 1'b0, t0);
        req = 4'b0000;
        tick();

        // 2: intermediate wrap, sticky overflow
        set_ops(0, 6'd20, 6'd15, -6'sd10);
        req = 4'b0001;
        servir("t2", 0, 6'd25, 1'b1, t0);
        req = 4'b0000;
        tick();

        // 3: round robin from reset
        set_ops(0, 6'd1, 6'd1, 6'd1);
        set_ops(1, 6'd2, 6'd2, 6'd2);
        set_ops(2, 6'd7, 6'd7, 6'd7);
        set_ops(3, 6'd3, 6'd3, 6'd3);
        req   = 4'b1011;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        servir("t3a", 0, 6'd3, 1'b0, t0);
        servir("t3b", 1, 6'd6, 1'b0, t1);
        chk("t3_gap01", 32'(t1 - t0), 32'd5);
        servir("t3c", 3, 6'd9, 1'b0, t0);
        chk("t3_gap13", 32'(t0 - t1), 32'd5);
        servir("t3d", 0, 6'd3, 1'b0, t1);
        chk("t3_gap30", 32'(t1 - t0), 32'd5);
        req = 4'b0000;
        tick();

        // 4: requester 1 abandons after first take
        set_ops(1, 6'd4, 6'd4, 6'd4);
        set_ops(2, 6'd10, -6'sd2, 6'd1);
        req = 4'b0110;
        n = 0;
        while (gnt == 4'b0000 && n < 30) begin
            tick();
            n++;
        end
        chk("t4_gnt1", 32'(gnt), 32'b0010);
        tick();
        req = 4'b0100;
        chk("t4_gnt1_hold", 32'(gnt), 32'b0010);
        tick();
        chk("t4_abandon_gnt", 32'(gnt), 32'd0);
        chk("t4_abandon_done", 32'(done), 32'd0);
        chk("t4_abandon_soma", {26'd0, soma}, 32'd3);
        tick();
        chk("t4_no_done", 32'(done), 32'd0);
        servir("t4", 2, 6'd9, 1'b0, t0);
        req = 4'b0000;
        tick();

        // 5: reset during second ACC cycle
        req = 4'b0010;
        n = 0;
        while (gnt == 4'b0000 && n < 30) begin
            tick();
            n++;
        end
        chk("t5_gnt1", 32'(gnt), 32'b0010);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_take", 32'(take), 32'd0);
        chk("t5_rst_soma", {26'd0, soma}, 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        chk("t5_rst_id", 32'(done_id), 32'd0);
        set_ops(0, 6'd5, 6'd7, -6'sd3);
        req = 4'b1111;
        #1;
        reset = 1'b0;
        servir("t5", 0, 6'd9, 1'b0, t0);
        req = 4'b0000;
        tick();

        // 6: extreme operands
        set_ops(0, -6'sd32, -6'sd32, -6'sd32);
        req = 4'b0001;
        servir("t6a", 0, -6'sd32, 1'b1, t0);
        req = 4'b0000;
        tick();
        set_ops(0, -6'sd32, 6'd31, 6'd0);
        req = 4'b0001;
        servir("t6b", 0, -6'sd1, 1'b0, t0);
        req = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
